// File: rtl/switch_allocator_pkg.sv
// Shared NoC parameters and types for the separable switch allocator.
package switch_allocator_pkg;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = 4;
  localparam int PORT_W   = 3;
  localparam int SEL_W    = $clog2(PORT_NUM);
  localparam int VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } inout_port_e;

  typedef struct packed {
    logic [VC_NUM-1:0] vc;
    logic              valid;
  } sa_grant_t;

  function automatic logic port_legal(input logic [PORT_W-1:0] port);
    return (port < PORT_W'(PORT_NUM));
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between VC status buffers, switch allocator and crossbar.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [PORT_NUM*VC_NUM-1:0]        sa_req_i;
  logic [PORT_NUM*VC_NUM*PORT_W-1:0] sa_port_i;
  logic [PORT_NUM*VC_NUM-1:0]        sa_tail_i;
  logic [PORT_NUM-1:0]               out_avail_i;
  logic [PORT_NUM*VC_NUM-1:0]        grant_vc_o;
  logic [PORT_NUM-1:0]               grant_valid_o;
  logic [PORT_NUM*SEL_W-1:0]         xbar_sel_o;
  logic [PORT_NUM-1:0]               xbar_valid_o;
  logic                              err_o;

  modport master (
    output sa_req_i, sa_port_i, sa_tail_i, out_avail_i,
    input  grant_vc_o, grant_valid_o, xbar_sel_o, xbar_valid_o, err_o
  );

  modport slave (
    input  sa_req_i, sa_port_i, sa_tail_i, out_avail_i,
    output grant_vc_o, grant_valid_o, xbar_sel_o, xbar_valid_o, err_o
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from ptr, pointer moves past the winner on upd_en.
module rr_arbiter
  import switch_allocator_pkg::*;
#(
  parameter int N = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             upd_en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] ptr_r;
  logic [N-1:0]     mask_s;
  logic [N-1:0]     req_hi_s;
  logic [N-1:0]     pick_s;

  // Search from ptr upward first, wrapping to the bottom when nothing is above it.
  always_comb begin
    mask_s   = {N{1'b1}} << ptr_r;
    req_hi_s = req & mask_s;
    pick_s   = (|req_hi_s) ? req_hi_s : req;
    idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_s[i]) begin
        idx = PTR_W'(i);
      end else begin
        idx = idx;
      end
    end
    valid = |req;
    grant = valid ? (N'(1) << idx) : '0;
  end

  // Pointer update on final grant only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (upd_en && valid) begin
      ptr_r <= (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator with registered inputs and grants.
// Optional packet-level output locking is enabled by defining SA_PKT_LOCK_EN.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  switch_allocator_if.slave sa
);

  logic [PORT_NUM-1:0][VC_NUM-1:0]             req_r;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0] port_r;
  logic [PORT_NUM-1:0]                         avail_r;
  logic [(1<<PORT_W)-1:0]                      avail_ext_s;

  logic [PORT_NUM-1:0][VC_NUM-1:0]   elig_s;
  logic [PORT_NUM-1:0][VC_NUM-1:0]   own_s;
  logic [PORT_NUM-1:0][VC_NUM-1:0]   blk_s;
  logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_req_s;
  logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_gnt_s;
  logic [PORT_NUM-1:0][VC_W-1:0]     s1_idx_s;
  logic [PORT_NUM-1:0]               s1_valid_s;
  logic [PORT_NUM-1:0][PORT_W-1:0]   s1_port_s;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req_s;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_gnt_s;
  logic [PORT_NUM-1:0][SEL_W-1:0]    s2_idx_s;
  logic [PORT_NUM-1:0]               s2_valid_s;
  logic [PORT_NUM-1:0]               in_win_s;
  logic                              err_s;

  sa_grant_t [PORT_NUM-1:0]       grant_r;
  logic [PORT_NUM-1:0][SEL_W-1:0] xbar_sel_r;
  logic [PORT_NUM-1:0]            xbar_valid_r;
  logic                           err_r;

`ifdef SA_PKT_LOCK_EN
  logic [PORT_NUM-1:0][VC_NUM-1:0] tail_r;
  logic [PORT_NUM-1:0]             lock_valid_r;
  logic [PORT_NUM-1:0][SEL_W-1:0]  lock_in_r;
  logic [PORT_NUM-1:0][VC_W-1:0]   lock_vc_r;
`else
  logic unused_tail_s;
  assign unused_tail_s = ^sa.sa_tail_i;
`endif

  assign avail_ext_s = {{((1<<PORT_W)-PORT_NUM){1'b0}}, avail_r};

  // Stage-1 eligibility: legal port, output available, and not blocked by another owner's lock.
  always_comb begin
    err_s  = 1'b0;
    elig_s = '0;
    own_s  = '0;
    blk_s  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        err_s = err_s | (req_r[p][v] & ~port_legal(port_r[p][v]));
`ifdef SA_PKT_LOCK_EN
        for (int o = 0; o < PORT_NUM; o++) begin
          if (lock_valid_r[o] && (port_r[p][v] == PORT_W'(o))) begin
            if ((lock_in_r[o] == SEL_W'(p)) && (lock_vc_r[o] == VC_W'(v))) begin
              own_s[p][v] = 1'b1;
            end else begin
              blk_s[p][v] = 1'b1;
            end
          end else begin
            blk_s[p][v] = blk_s[p][v];
          end
        end
`endif
        elig_s[p][v] = req_r[p][v] & port_legal(port_r[p][v]) &
                       avail_ext_s[port_r[p][v]] & ~blk_s[p][v];
        own_s[p][v]  = own_s[p][v] & elig_s[p][v];
      end
      // A requesting locked VC overrides the pointer; lowest locked VC wins.
      s1_req_s[p] = (|own_s[p]) ? (own_s[p] & (~own_s[p] + VC_NUM'(1))) : elig_s[p];
    end
  end

  for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_stage1
    rr_arbiter #(.N(VC_NUM)) u_in_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (s1_req_s[gp]),
      .upd_en (in_win_s[gp]),
      .grant  (s1_gnt_s[gp]),
      .idx    (s1_idx_s[gp]),
      .valid  (s1_valid_s[gp])
    );
  end

  // Stage-2 requests: each input's stage-1 winner asks for its target output.
  always_comb begin
    s2_req_s  = '0;
    s1_port_s = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_port_s[p] = port_r[p][s1_idx_s[p]];
      for (int o = 0; o < PORT_NUM; o++) begin
        s2_req_s[o][p] = s1_valid_s[p] & (s1_port_s[p] == PORT_W'(o));
      end
    end
  end

  for (genvar go = 0; go < PORT_NUM; go++) begin : g_stage2
    rr_arbiter #(.N(PORT_NUM)) u_out_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (s2_req_s[go]),
      .upd_en (1'b1),
      .grant  (s2_gnt_s[go]),
      .idx    (s2_idx_s[go]),
      .valid  (s2_valid_s[go])
    );
  end

  // An input is finally granted when some output picked it.
  always_comb begin
    in_win_s = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        in_win_s[p] = in_win_s[p] | s2_gnt_s[o][p];
      end
    end
  end

  // Input sampling and grant registers; xbar_sel holds when its output is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r        <= '0;
      port_r       <= '0;
      avail_r      <= '0;
      grant_r      <= '0;
      xbar_sel_r   <= '0;
      xbar_valid_r <= '0;
      err_r        <= 1'b0;
    end else begin
      req_r   <= sa.sa_req_i;
      port_r  <= sa.sa_port_i;
      avail_r <= sa.out_avail_i;
      for (int p = 0; p < PORT_NUM; p++) begin
        grant_r[p].vc    <= in_win_s[p] ? s1_gnt_s[p] : '0;
        grant_r[p].valid <= in_win_s[p];
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        xbar_valid_r[o] <= s2_valid_s[o];
        if (s2_valid_s[o]) begin
          xbar_sel_r[o] <= s2_idx_s[o];
        end else begin
          xbar_sel_r[o] <= xbar_sel_r[o];
        end
      end
      err_r <= err_s;
    end
  end

`ifdef SA_PKT_LOCK_EN
  // Lock an output to the granted (input, VC) until that VC's tail flit is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tail_r       <= '0;
      lock_valid_r <= '0;
      lock_in_r    <= '0;
      lock_vc_r    <= '0;
    end else begin
      tail_r <= sa.sa_tail_i;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (s2_valid_s[o]) begin
          if (tail_r[s2_idx_s[o]][s1_idx_s[s2_idx_s[o]]]) begin
            lock_valid_r[o] <= 1'b0;
          end else begin
            lock_valid_r[o] <= 1'b1;
            lock_in_r[o]    <= s2_idx_s[o];
            lock_vc_r[o]    <= s1_idx_s[s2_idx_s[o]];
          end
        end else begin
          lock_valid_r[o] <= lock_valid_r[o];
        end
      end
    end
  end
`endif

  for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_out
    assign sa.grant_vc_o[gp*VC_NUM +: VC_NUM] = grant_r[gp].vc;
    assign sa.grant_valid_o[gp]               = grant_r[gp].valid;
  end
  assign sa.xbar_sel_o   = xbar_sel_r;
  assign sa.xbar_valid_o = xbar_valid_r;
  assign sa.err_o        = err_r;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator; expectations follow the SA_PKT_LOCK_EN setting.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  switch_allocator_if sa ();

  switch_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sa.sa_req_i    = '0;
    sa.sa_port_i   = '0;
    sa.sa_tail_i   = '0;
    sa.out_avail_i = '1;
  endtask

  task automatic set_req(input int p, input int v, input logic [2:0] port, input logic tail);
    int i;
    i = p * VC_NUM + v;
    sa.sa_req_i[i]              = 1'b1;
    sa.sa_port_i[i*PORT_W +: 3] = port;
    sa.sa_tail_i[i]             = tail;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] all_out;
    clear_inputs();
    sa.sa_req_i = '1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      all_out = {sa.grant_vc_o, sa.grant_valid_o, sa.xbar_sel_o, sa.xbar_valid_o, sa.err_o};
      checks++;
      if (all_out !== 36'd0) begin
        $display("FAIL reset_outputs cycle %0d got=%h want=0", c, all_out); errors++;
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (sa.grant_valid_o !== 5'b00000) begin
      $display("FAIL reset_first_edge grant_valid got=%b want=00000", sa.grant_valid_o); errors++;
    end
    tick();
    checks++;
    if ({sa.grant_vc_o, sa.grant_valid_o, sa.xbar_valid_o} !== {10'b0000000001, 5'b00001, 5'b00001}) begin
      $display("FAIL reset_first_grant got=%b/%b/%b want=0000000001/00001/00001",
               sa.grant_vc_o, sa.grant_valid_o, sa.xbar_valid_o); errors++;
    end
    checks++;
    if (sa.xbar_sel_o[2:0] !== 3'd0) begin
      $display("FAIL reset_first_sel got=%0d want=0", sa.xbar_sel_o[2:0]); errors++;
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(NORTH, 1, EAST, 1'b0);
    tick();
    tick();
    checks++;
    if ({sa.grant_vc_o, sa.grant_valid_o} !== {10'b0000001000, 5'b00010}) begin
      $display("FAIL single_grant got=%b/%b want=0000001000/00010", sa.grant_vc_o, sa.grant_valid_o); errors++;
    end
    checks++;
    if ({sa.xbar_sel_o[EAST*SEL_W +: SEL_W], sa.xbar_valid_o} !== {3'd1, 5'b10000}) begin
      $display("FAIL single_xbar got=%0d/%b want=1/10000", sa.xbar_sel_o[EAST*SEL_W +: SEL_W], sa.xbar_valid_o); errors++;
    end
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[EAST*SEL_W +: SEL_W]} !== {5'b0, 5'b0, 3'd1}) begin
      $display("FAIL idle_hold got=%b/%b/%0d want=00000/00000/1",
               sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[EAST*SEL_W +: SEL_W]); errors++;
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp_gv;
    logic [2:0] exp_sel;
    do_reset();
    for (int p = 0; p < PORT_NUM; p++) set_req(p, 0, EAST, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_gv  = 5'b00001 << (k % 5);
      exp_sel = 3'(k % 5);
      checks++;
      if ({sa.xbar_sel_o[EAST*SEL_W +: SEL_W], sa.xbar_valid_o, sa.grant_valid_o} !== {exp_sel, 5'b10000, exp_gv}) begin
        $display("FAIL contention cycle %0d got sel=%0d xv=%b gv=%b want sel=%0d xv=10000 gv=%b",
                 k, sa.xbar_sel_o[EAST*SEL_W +: SEL_W], sa.xbar_valid_o, sa.grant_valid_o, exp_sel, exp_gv); errors++;
      end
    end
  endtask

  task automatic test_vc_fairness();
    logic [1:0] exp_vc;
    logic [4:0] exp_xv;
    do_reset();
    set_req(0, 0, NORTH, 1'b0);
    set_req(0, 1, SOUTH, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_vc = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_xv = (k % 2 == 0) ? 5'b00010 : 5'b00100;
      checks++;
      if ({sa.grant_vc_o[1:0], sa.xbar_valid_o} !== {exp_vc, exp_xv}) begin
        $display("FAIL vc_alternate cycle %0d got=%b/%b want=%b/%b", k, sa.grant_vc_o[1:0], sa.xbar_valid_o, exp_vc, exp_xv); errors++;
      end
    end
    // Move out_ptr[NORTH] to 1 and in_ptr[0] back to 0, then make input 0 lose NORTH once.
    do_reset();
    set_req(0, 1, NORTH, 1'b0);
    tick();
    clear_inputs();
    set_req(0, 0, NORTH, 1'b0);
    set_req(0, 1, SOUTH, 1'b0);
    set_req(1, 0, NORTH, 1'b0);
    tick();
    checks++;
    if ({sa.grant_vc_o[1:0], sa.xbar_valid_o} !== {2'b10, 5'b00010}) begin
      $display("FAIL ptr_setup got=%b/%b want=10/00010", sa.grant_vc_o[1:0], sa.xbar_valid_o); errors++;
    end
    tick();
    checks++;
    if ({sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[NORTH*SEL_W +: SEL_W]} !== {5'b00010, 5'b00010, 3'd1}) begin
      $display("FAIL stage2_loss got=%b/%b/%0d want=00010/00010/1",
               sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[NORTH*SEL_W +: SEL_W]); errors++;
    end
    tick();
    checks++;
    if ({sa.grant_vc_o[1:0], sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[NORTH*SEL_W +: SEL_W]} !==
        {2'b01, 5'b00001, 5'b00010, 3'd0}) begin
      $display("FAIL in_ptr_held got=%b/%b/%b/%0d want=01/00001/00010/0", sa.grant_vc_o[1:0],
               sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[NORTH*SEL_W +: SEL_W]); errors++;
    end
  endtask

  task automatic test_flow_control();
    do_reset();
    sa.out_avail_i[WEST] = 1'b0;
    set_req(2, 0, WEST, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({sa.grant_valid_o, sa.xbar_valid_o} !== 10'b0) begin
        $display("FAIL blocked_west cycle %0d got=%b/%b want=00000/00000", k, sa.grant_valid_o, sa.xbar_valid_o); errors++;
      end
    end
    sa.out_avail_i[WEST] = 1'b1;
    tick();
    tick();
    checks++;
    if ({sa.grant_vc_o[5:4], sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[WEST*SEL_W +: SEL_W]} !==
        {2'b01, 5'b00100, 5'b01000, 3'd2}) begin
      $display("FAIL unblocked_west got=%b/%b/%b/%0d want=01/00100/01000/2", sa.grant_vc_o[5:4],
               sa.grant_valid_o, sa.xbar_valid_o, sa.xbar_sel_o[WEST*SEL_W +: SEL_W]); errors++;
    end
    do_reset();
    set_req(3, 1, 3'd6, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if ({sa.err_o, sa.grant_valid_o, sa.xbar_valid_o} !== {1'b1, 5'b0, 5'b0}) begin
      $display("FAIL illegal_port got err=%b gv=%b xv=%b want 1/00000/00000", sa.err_o, sa.grant_valid_o, sa.xbar_valid_o); errors++;
    end
    tick();
    checks++;
    if (sa.err_o !== 1'b0) begin
      $display("FAIL err_pulse got=%b want=0", sa.err_o); errors++;
    end
  endtask

  task automatic test_pkt_lock();
    logic [2:0] exp_sel;
    logic [4:0] exp_gv;
    do_reset();
    set_req(1, 0, LOCAL, 1'b0);
    set_req(2, 0, LOCAL, 1'b0);
    tick();
    for (int c = 1; c <= 6; c++) begin
      tick();
`ifdef SA_PKT_LOCK_EN
      exp_sel = (c <= 5) ? 3'd1 : 3'd2;
`else
      exp_sel = (c % 2 == 1) ? 3'd1 : 3'd2;
`endif
      exp_gv = 5'b00001 << exp_sel;
      checks++;
      if ({sa.xbar_sel_o[2:0], sa.xbar_valid_o, sa.grant_valid_o} !== {exp_sel, 5'b00001, exp_gv}) begin
        $display("FAIL pkt_lock cycle %0d got sel=%0d xv=%b gv=%b want sel=%0d xv=00001 gv=%b",
                 c, sa.xbar_sel_o[2:0], sa.xbar_valid_o, sa.grant_valid_o, exp_sel, exp_gv); errors++;
      end
      if (c == 3) sa.sa_tail_i[1*VC_NUM] = 1'b1;
      if (c == 4) sa.sa_req_i[1*VC_NUM] = 1'b0;
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_vc_fairness();
    test_flow_control();
    test_pkt_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
